// File: rtl/analog_intl_scan_pkg.sv
// Shared constants and the magnitude/NaN over-limit test for the analog interlock scanner.
package analog_intl_pkg;

  localparam int NUM_CH = 7;
  localparam int DATA_W = 32;
  localparam int DEB_W  = 16;
  localparam int CH_W   = 3;

  localparam logic [CH_W-1:0] CH_C      = 3'd0;
  localparam logic [CH_W-1:0] CH_V      = 3'd1;
  localparam logic [CH_W-1:0] CH_DC_C   = 3'd2;
  localparam logic [CH_W-1:0] CH_DC_V   = 3'd3;
  localparam logic [CH_W-1:0] CH_IGBT_T = 3'd4;
  localparam logic [CH_W-1:0] CH_I_ID_T = 3'd5;
  localparam logic [CH_W-1:0] CH_O_ID_T = 3'd6;

  // Positive IEEE-754 magnitudes order like unsigned integers, so bits[30:0]
  // compare directly; an all-ones exponent (NaN/Inf) always counts as over.
  function automatic logic f_mag_over(input logic [DATA_W-1:0] meas,
                                      input logic [DATA_W-1:0] sp);
    if (meas[30:23] == 8'hFF) return 1'b1;
    return meas[30:0] > sp[30:0];
  endfunction

endpackage

// File: rtl/analog_intl_scan_if.sv
// Measurement, setpoint and fault signals between the interlock environment and the scanner.
interface analog_intl_scan_if;
  import analog_intl_pkg::*;

  logic [NUM_CH*DATA_W-1:0] i_meas;
  logic [NUM_CH-1:0]        i_meas_valid;
  logic [NUM_CH*DATA_W-1:0] i_sp;
  logic [NUM_CH-1:0]        i_ch_en;
  logic [DEB_W-1:0]         i_deb_cnt;
  logic                     i_intl_clr;
  logic [NUM_CH-1:0]        o_fault;
  logic                     o_intl;
  logic [CH_W-1:0]          o_first_ch;
  logic                     o_first_valid;
  logic [NUM_CH-1:0]        o_ovr;

  modport master (
    output i_meas, i_meas_valid, i_sp, i_ch_en, i_deb_cnt, i_intl_clr,
    input  o_fault, o_intl, o_first_ch, o_first_valid, o_ovr
  );

  modport slave (
    input  i_meas, i_meas_valid, i_sp, i_ch_en, i_deb_cnt, i_intl_clr,
    output o_fault, o_intl, o_first_ch, o_first_valid, o_ovr
  );

endinterface

// File: rtl/intl_debounce_bank.sv
// Per-channel consecutive-over counters sharing one update path; flags a trip for the addressed channel.
module intl_debounce_bank
  import analog_intl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              over_i,
  input  logic [CH_W-1:0]   ch_i,
  input  logic [NUM_CH-1:0] ch_en_i,
  input  logic [DEB_W-1:0]  deb_cnt_i,
  input  logic              clr_i,
  output logic              trip_o,
  output logic [CH_W-1:0]   trip_ch_o
);

  logic [DEB_W-1:0] cnt_q [NUM_CH];
  logic [DEB_W-1:0] cnt_d [NUM_CH];
  logic [DEB_W-1:0] deb_eff;
  logic [DEB_W:0]   cnt_inc;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    deb_eff = (deb_cnt_i == '0) ? DEB_W'(1) : deb_cnt_i;
    cnt_inc = {1'b0, cnt_q[ch_i]} + 1'b1;
    cnt_d   = cnt_q;
    trip_o  = 1'b0;
    if (valid_i) begin
      if (over_i) begin
        trip_o      = (cnt_inc >= {1'b0, deb_eff});
        cnt_d[ch_i] = trip_o ? deb_eff : cnt_inc[DEB_W-1:0];
      end else begin
        cnt_d[ch_i] = '0;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (!ch_en_i[k] || clr_i) cnt_d[k] = '0;
    end
    if (clr_i) trip_o = 1'b0;
  end

  assign trip_ch_o = ch_i;

  // NOTE: sequential state uses non-blocking assignments; the counters are reset because they carry trip history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_d[k];
    end
  end

endmodule

// File: rtl/analog_intl_scan.sv
// Round-robin over-limit scanner: per-channel sample hold, shared compare stage, shared debounce, sticky faults.
module analog_intl_scan
  import analog_intl_pkg::*;
(
  input logic               i_clk,
  input logic               i_rst,
  analog_intl_scan_if.slave bus
);

  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] ovr_q, ovr_d;
  logic [NUM_CH-1:0] consume;
  logic [DATA_W-1:0] hold_q [NUM_CH];
  logic [DATA_W-1:0] sp_sel;

  logic              s1_v_q, s1_v_d;
  logic              s1_over_q, s1_over_d;
  logic [CH_W-1:0]   s1_ch_q;

  logic [NUM_CH-1:0] fault_q, fault_d;
  logic              intl_q;
  logic [CH_W-1:0]   first_ch_q, first_ch_d;
  logic              first_valid_q, first_valid_d;
  logic              trip;
  logic [CH_W-1:0]   trip_ch;

  // Capture and stage-1 selection; a new strobe wins over a same-cycle consume so the fresh sample stays pending.
  always_comb begin
    consume          = '0;
    consume[ptr_q]   = pend_q[ptr_q];
    ptr_d            = (ptr_q == CH_O_ID_T) ? CH_C : ptr_q + 1'b1;
    sp_sel           = bus.i_sp[int'(ptr_q)*DATA_W +: DATA_W];
    s1_v_d           = pend_q[ptr_q] & bus.i_ch_en[ptr_q];
    s1_over_d        = f_mag_over(hold_q[ptr_q], sp_sel);
    pend_d           = (pend_q & ~consume) | bus.i_meas_valid;
    ovr_d            = bus.i_intl_clr ? '0
                     : ovr_q | (bus.i_meas_valid & pend_q & ~consume);
  end

  // Sample payloads are qualified by pend_q, so they need no reset.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.i_meas_valid[k]) hold_q[k] <= bus.i_meas[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ptr_q     <= CH_C;
      pend_q    <= '0;
      ovr_q     <= '0;
      s1_v_q    <= 1'b0;
      s1_over_q <= 1'b0;
      s1_ch_q   <= CH_C;
    end else begin
      ptr_q     <= ptr_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      s1_v_q    <= s1_v_d;
      s1_over_q <= s1_over_d;
      s1_ch_q   <= ptr_q;
    end
  end

  intl_debounce_bank u_deb (
    .clk       (i_clk),
    .rst_n     (i_rst),
    .valid_i   (s1_v_q),
    .over_i    (s1_over_q),
    .ch_i      (s1_ch_q),
    .ch_en_i   (bus.i_ch_en),
    .deb_cnt_i (bus.i_deb_cnt),
    .clr_i     (bus.i_intl_clr),
    .trip_o    (trip),
    .trip_ch_o (trip_ch)
  );

  // Stage 2: sticky faults and first-out; a single trip per cycle means first-out never has ties.
  always_comb begin
    fault_d       = fault_q;
    first_ch_d    = first_ch_q;
    first_valid_d = first_valid_q;
    if (trip) begin
      fault_d[trip_ch] = 1'b1;
      if (!first_valid_q) begin
        first_ch_d    = trip_ch;
        first_valid_d = 1'b1;
      end
    end
    if (bus.i_intl_clr) begin
      fault_d       = '0;
      first_ch_d    = '0;
      first_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      fault_q       <= '0;
      intl_q        <= 1'b0;
      first_ch_q    <= '0;
      first_valid_q <= 1'b0;
    end else begin
      fault_q       <= fault_d;
      intl_q        <= |fault_q;
      first_ch_q    <= first_ch_d;
      first_valid_q <= first_valid_d;
    end
  end

  assign bus.o_fault       = fault_q;
  assign bus.o_intl        = intl_q;
  assign bus.o_first_ch    = first_ch_q;
  assign bus.o_first_valid = first_valid_q;
  assign bus.o_ovr         = ovr_q;

endmodule

// File: tb/tb_analog_intl_scan.sv
// Directed bench for analog_intl_scan; expected fault vectors are queued at stimulus time and popped when o_fault changes.
module tb_analog_intl_scan;
  import analog_intl_pkg::*;

  localparam logic [31:0] SP200  = 32'h43480000;
  localparam logic [31:0] OV201  = 32'h43490000;
  localparam logic [31:0] UN199  = 32'h43470000;
  localparam logic [31:0] NEG201 = 32'hC3490000;
  localparam logic [31:0] QNAN   = 32'h7FC00000;
  localparam int          LAT    = NUM_CH + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [NUM_CH-1:0] exp_q [$];

  analog_intl_scan_if bus ();

  analog_intl_scan dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input int ch, input logic [31:0] val);
    bus.i_meas[ch*DATA_W +: DATA_W] = val;
    bus.i_meas_valid     = '0;
    bus.i_meas_valid[ch] = 1'b1;
    tick(1);
    bus.i_meas_valid = '0;
  endtask

  // Eight-cycle spacing keeps every sample consumed before the next arrives.
  task automatic strobe_n(input int ch, input logic [31:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      strobe(ch, val);
      if (i != n - 1) tick(7);
    end
  endtask

  task automatic expect_trip(input string tag, input int budget);
    logic [NUM_CH-1:0] exp_v;
    logic [NUM_CH-1:0] old_v;
    int n;
    exp_v = exp_q.pop_front();
    old_v = bus.o_fault;
    n = 0;
    while (bus.o_fault === old_v && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, bus.o_fault, exp_v);
  endtask

  task automatic do_clear(input string tag);
    bus.i_intl_clr = 1'b1;
    tick(1);
    bus.i_intl_clr = 1'b0;
    check({tag, "_fault"},  bus.o_fault, 0);
    check({tag, "_ovr"},    bus.o_ovr, 0);
    check({tag, "_fvalid"}, bus.o_first_valid, 0);
    check({tag, "_fch"},    bus.o_first_ch, 0);
  endtask

  initial begin
    bus.i_meas       = '0;
    bus.i_meas_valid = '0;
    bus.i_sp         = {NUM_CH{SP200}};
    bus.i_ch_en      = 7'h3F;
    bus.i_deb_cnt    = 16'd3;
    bus.i_intl_clr   = 1'b0;

    tick(2);
    check("rst_fault",  bus.o_fault, 0);
    check("rst_intl",   bus.o_intl, 0);
    check("rst_fch",    bus.o_first_ch, 0);
    check("rst_fvalid", bus.o_first_valid, 0);
    check("rst_ovr",    bus.o_ovr, 0);
    rst_n = 1'b1;
    tick(2);

    // Trip after three consecutive over samples
    strobe_n(0, OV201, 2);
    tick(LAT);
    check("t1_no_trip_after_2", bus.o_fault, 0);
    strobe(0, OV201);
    exp_q.push_back(7'h01);
    expect_trip("t1_trip", LAT);
    check("t1_fch",       bus.o_first_ch, 0);
    check("t1_fvalid",    bus.o_first_valid, 1);
    check("t1_intl_lag",  bus.o_intl, 0);
    tick(1);
    check("t1_intl",      bus.o_intl, 1);
    check("t1_no_ovr",    bus.o_ovr, 0);

    // An under sample restarts the debounce count
    do_clear("t2_clr");
    tick(1);
    check("t2_intl_clr", bus.o_intl, 0);
    strobe_n(1, OV201, 2);
    tick(7);
    strobe(1, UN199);
    tick(7);
    strobe_n(1, OV201, 2);
    tick(LAT);
    check("t2_no_trip", bus.o_fault, 0);
    strobe(1, OV201);
    exp_q.push_back(7'h02);
    expect_trip("t2_trip_after_3_fresh", LAT);

    // First-out and sign-magnitude compare
    do_clear("t3_clr");
    strobe_n(4, OV201, 3);
    exp_q.push_back(7'h10);
    expect_trip("t3_ch4", LAT);
    tick(2);
    strobe_n(2, NEG201, 3);
    exp_q.push_back(7'h14);
    expect_trip("t3_ch2_negative", LAT);
    check("t3_fch",    bus.o_first_ch, 4);
    check("t3_fvalid", bus.o_first_valid, 1);

    // Overrun, NaN, equality boundary, deb=0, disable, stickiness
    do_clear("t4_clr");
    bus.i_meas[5*DATA_W +: DATA_W] = UN199;
    bus.i_meas_valid = 7'h20;
    tick(3);
    bus.i_meas_valid = '0;
    tick(1);
    check("t4_ovr", bus.o_ovr, 7'h20);
    tick(LAT);
    check("t4_ovr_no_fault", bus.o_fault, 0);

    bus.i_sp[3*DATA_W +: DATA_W] = 32'h7FFFFFFF;
    bus.i_deb_cnt = 16'd1;
    strobe(3, QNAN);
    exp_q.push_back(7'h08);
    expect_trip("t4_nan", LAT);
    check("t4_nan_fch", bus.o_first_ch, 3);

    strobe(0, SP200);
    tick(LAT);
    check("t4_equal_not_over", bus.o_fault, 7'h08);

    bus.i_deb_cnt = 16'd0;
    strobe(0, OV201);
    exp_q.push_back(7'h09);
    expect_trip("t4_deb0_as_1", LAT);

    bus.i_deb_cnt = 16'd1;
    strobe_n(6, OV201, 3);
    tick(LAT);
    check("t4_disabled_ch6", bus.o_fault, 7'h09);

    strobe(0, UN199);
    tick(LAT);
    check("t4_sticky", bus.o_fault, 7'h09);

    // Clear while over samples keep arriving; retrip needs deb fresh samples
    bus.i_deb_cnt = 16'd2;
    strobe(0, OV201);
    tick(LAT);
    bus.i_meas[0*DATA_W +: DATA_W] = OV201;
    bus.i_meas_valid = 7'h01;
    bus.i_intl_clr   = 1'b1;
    tick(1);
    bus.i_meas_valid = '0;
    bus.i_intl_clr   = 1'b0;
    check("t5_fault", bus.o_fault, 0);
    check("t5_ovr",   bus.o_ovr, 0);
    check("t5_fvalid", bus.o_first_valid, 0);
    tick(1);
    check("t5_intl", bus.o_intl, 0);
    tick(LAT);
    check("t5_one_fresh_no_trip", bus.o_fault, 0);
    strobe(0, OV201);
    exp_q.push_back(7'h01);
    expect_trip("t5_retrip", LAT);
    check("t5_fch", bus.o_first_ch, 0);

    // Asynchronous reset with samples pending
    bus.i_deb_cnt = 16'd1;
    for (int k = 0; k < 6; k++) bus.i_meas[k*DATA_W +: DATA_W] = OV201;
    bus.i_meas_valid = 7'h3F;
    tick(1);
    bus.i_meas_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_fault",  bus.o_fault, 0);
    check("t6_async_intl",   bus.o_intl, 0);
    check("t6_async_fvalid", bus.o_first_valid, 0);
    check("t6_async_ovr",    bus.o_ovr, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2 * LAT);
    check("t6_pending_lost", bus.o_fault, 0);
    strobe(0, OV201);
    exp_q.push_back(7'h01);
    expect_trip("t6_resume", LAT);
    check("t6_fch", bus.o_first_ch, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/analog_intl_scan.md
Name: analog_intl_scan

Overview:
- Time-multiplexed over-limit checker for the analog interlock. One magnitude comparator and one debounce updater are shared round-robin across 7 analog channels.
- Takes the over-setpoints produced by the interlock register block and measured samples from the ADC/scaling path. Raises sticky per-channel faults, a summary interlock, and a first-out record for the MPS fault handler.

Parameters:
- NUM_CH, 7, number of scanned channels. Index order: 0 c, 1 v, 2 dc_c, 3 dc_v, 4 igbt_t, 5 i_id_t, 6 o_id_t.
- DATA_W, 32, IEEE-754 single word width.
- DEB_W, 16, debounce counter width.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-low reset
- i_meas  in  NUM_CH*DATA_W  packed measured values; channel k at [k*32+:32]
- i_meas_valid  in  NUM_CH  per-channel one-cycle sample strobe
- i_sp  in  NUM_CH*DATA_W  packed over-setpoints, same packing; quasi-static
- i_ch_en  in  NUM_CH  per-channel check enable
- i_deb_cnt  in  DEB_W  consecutive over-samples required to trip; 0 is treated as 1
- i_intl_clr  in  1  level clear of faults and first-out
- o_fault  out  NUM_CH  sticky per-channel trip
- o_intl  out  1  OR of o_fault, registered
- o_first_ch  out  3  channel index of the first trip
- o_first_valid  out  1  o_first_ch holds a valid index
- o_ovr  out  NUM_CH  sticky: a sample arrived while the previous sample for that channel was still pending

Behaviour:
- Reset (i_rst=0, async): all outputs 0, pointer 0, all pending flags 0, all debounce counters 0, all pipeline valids 0.
- Capture, per channel k:
  - On i_meas_valid[k], the hold register takes i_meas[k] and pend[k] is set.
  - If pend[k] is already set and stage 1 does not consume it in that cycle, o_ovr[k] is set and the new value overwrites the old.
  - If valid and consume coincide, the new sample is held and pend[k] stays 1.
- Scan pointer ptr: increments every cycle, wraps NUM_CH-1 -> 0. The scan is fixed TDM, not skip-ahead.
- Stage 1 (registered): s1_v = pend[ptr] & i_ch_en[ptr]; s1_ch = ptr.
  - over = |meas| > |sp| on bits[30:0], unsigned compare; the sign bit is ignored.
  - Exponent 0xFF in meas (NaN/Inf) forces over=1.
  - pend[ptr] is cleared when consumed.
  - A disabled channel's pending flag is cleared without a check.
- Stage 2 (registered), if s1_v:
  - When over: cnt[ch] = min(cnt+1, deb_eff), where deb_eff = max(i_deb_cnt, 1).
  - When not over: cnt[ch] = 0.
  - Trip when over and cnt+1 >= deb_eff: o_fault[ch] <= 1.
- Latency: strobe at cycle t -> o_fault set at t+NUM_CH+2 at the latest and t+2 at the earliest; o_intl follows one cycle later.
- Disabled channel: cnt is held at 0 and no trip occurs. An already-set fault is not cleared by disable.
- First-out: on the first trip while o_first_valid=0, latch ch and set o_first_valid.
  - Only one channel per cycle can trip (single stage 2), so there are no ties.
- Clear, while i_intl_clr=1:
  - o_fault, o_ovr, o_first_valid, o_first_ch and all cnt are forced to 0 each cycle.
  - Stage-2 trips are suppressed. Capture and scanning continue.
  - The first trip can occur the cycle after clear deasserts.
- Sticky faults persist through measurement recovery.
- Setpoint changes take effect at the next stage-1 evaluation of that channel.

Decomposition:
- Package analog_intl_pkg:
  - channel index constants CH_C..CH_O_ID_T
  - NUM_CH and the width constants
  - function f_mag_over(meas, sp) covering the compare and NaN rule
- One sub-module, intl_debounce_bank: the counter array plus trip/saturate logic, addressed by channel index.

Test Plan:
- Trip after debounce:
  - Stimulus: sp[0]=0x43480000 (200.0), i_deb_cnt=3, three strobes on ch0 with 0x43490000 (201.0), spaced 8 cycles.
  - Response: o_fault=7'h01 only after the 3rd sample; o_first_ch=0, o_first_valid=1; o_intl one cycle later.
- Debounce reset:
  - Stimulus: ch1 samples over, over, under (0x43470000), over, over.
  - Response: no trip; cnt returns to 0 after the under sample.
- First-out and sign handling:
  - Stimulus: ch4 trips first, then ch2 trips; separately, a negative value 0xC3490000 against sp 200.0.
  - Response: o_fault=7'h14, o_first_ch=4; the negative value is treated as |-201| and counts as over.
- Overrun, NaN and disable:
  - Stimulus: two ch5 strobes 1 cycle apart while ptr is far from 5; separately, a 0x7FC00000 sample with deb=1; separately, i_ch_en[6]=0 with over samples on ch6.
  - Response: o_ovr[5]=1; the NaN sample trips immediately; ch6 never faults.
- Clear:
  - Stimulus: i_intl_clr high for 1 cycle with faults set and over samples still arriving.
  - Response: all sticky outputs go to 0. The first retrip is no earlier than the cycle after clear deasserts, and requires deb fresh samples.
- Reset mid-operation:
  - Stimulus: assert i_rst during active scanning with pending samples.
  - Response: outputs 0 asynchronously, pending flags lost; normal operation resumes after release.
